// File: rtl/bcd_timekeeper_if.sv
// Control pulses in, BCD time of day and status out, for the 24-hour timekeeper.
// master = controller/prescaler side, slave = timekeeper side.
interface bcd_timekeeper_if;
   logic        tick;
   logic        start;
   logic        stop;
   logic        clear;
   logic        load;
   logic [23:0] load_time;
   logic [7:0]  hours;
   logic [7:0]  minutes;
   logic [7:0]  seconds;
   logic        running;
   logic        day_tick;
   logic        load_err;

   modport master (
      output tick, start, stop, clear, load, load_time,
      input  hours, minutes, seconds, running, day_tick, load_err
   );

   modport slave (
      input  tick, start, stop, clear, load, load_time,
      output hours, minutes, seconds, running, day_tick, load_err
   );
endinterface

// File: rtl/bcd_timekeeper.sv
// 24-hour BCD time-of-day counter driven by a 1 Hz enable, with IDLE/RUN/PAUSE control.
// Time, running and load_err are registered (1-cycle latency); day_tick is combinational.
module bcd_timekeeper (
   input  logic                    clk,
   input  logic                    reset,
   bcd_timekeeper_if.slave         tk_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   state_e      state_q;
   logic        running_q;
   logic        load_err_q;
   logic [23:0] time_q;
   logic [23:0] time_d;
   logic [23:0] time_inc;
   logic        load_ok;
   logic        at_max;

   logic [3:0] h1, h0, m1, m0, s1, s0;
   logic [3:0] lh1, lh0, lm1, lm0, ls1, ls0;

   assign {h1, h0, m1, m0, s1, s0}       = time_q;
   assign {lh1, lh0, lm1, lm0, ls1, ls0} = tk_if.load_time;

   assign at_max = (time_q == 24'h235959);

   // Hours are range-checked as a pair: 0x-1x take any units digit, 2x only up to 3.
   assign load_ok = (lh0 <= 4'd9) && (lm1 <= 4'd5) && (lm0 <= 4'd9) &&
                    (ls1 <= 4'd5) && (ls0 <= 4'd9) &&
                    ((lh1 <= 4'd1) || ((lh1 == 4'd2) && (lh0 <= 4'd3)));

   always_comb begin
      logic [3:0] nh1, nh0, nm1, nm0, ns1, ns0;
      nh1 = h1;
      nh0 = h0;
      nm1 = m1;
      nm0 = m0;
      ns1 = s1;
      ns0 = s0;
      if (s0 != 4'd9) begin
         ns0 = s0 + 4'd1;
      end else begin
         ns0 = 4'd0;
         if (s1 != 4'd5) begin
            ns1 = s1 + 4'd1;
         end else begin
            ns1 = 4'd0;
            if (m0 != 4'd9) begin
               nm0 = m0 + 4'd1;
            end else begin
               nm0 = 4'd0;
               if (m1 != 4'd5) begin
                  nm1 = m1 + 4'd1;
               end else begin
                  nm1 = 4'd0;
                  if ((h1 == 4'd2) && (h0 == 4'd3)) begin
                     nh1 = 4'd0;
                     nh0 = 4'd0;
                  end else if (h0 == 4'd9) begin
                     nh1 = h1 + 4'd1;
                     nh0 = 4'd0;
                  end else begin
                     nh0 = h0 + 4'd1;
                  end
               end
            end
         end
      end
      time_inc = {nh1, nh0, nm1, nm0, ns1, ns0};
   end

   // clear and load both suppress counting for the cycle, even when load itself is ignored.
   always_comb begin
      time_d = time_q;
      if (tk_if.clear) begin
         time_d = 24'h000000;
      end else if (tk_if.load) begin
         if ((state_q != RUN) && load_ok) begin
            time_d = tk_if.load_time;
         end
      end else if ((state_q == RUN) && tk_if.tick) begin
         time_d = time_inc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         running_q  <= 1'b0;
         load_err_q <= 1'b0;
         time_q     <= 24'h000000;
      end else begin
         time_q     <= time_d;
         load_err_q <= 1'b0;
         if (tk_if.clear) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
         end else if (tk_if.load) begin
            if (state_q != RUN) begin
               if (load_ok) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end else begin
                  load_err_q <= 1'b1;
               end
            end
         end else if (tk_if.stop) begin
            if (state_q == RUN) begin
               state_q   <= PAUSE;
               running_q <= 1'b0;
            end
         end else if (tk_if.start) begin
            if (state_q != RUN) begin
               state_q   <= RUN;
               running_q <= 1'b1;
            end
         end
      end
   end

   assign tk_if.hours    = time_q[23:16];
   assign tk_if.minutes  = time_q[15:8];
   assign tk_if.seconds  = time_q[7:0];
   assign tk_if.running  = running_q;
   assign tk_if.load_err = load_err_q;
   assign tk_if.day_tick = (state_q == RUN) && tk_if.tick && at_max &&
                           !tk_if.clear && !tk_if.load;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Bench for bcd_timekeeper: seconds-of-day reference model, per-cycle compare, directed and random stimulus.
module tb_bcd_timekeeper;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   bcd_timekeeper_if tif ();

   bcd_timekeeper dut (
      .clk   (clk),
      .reset (reset),
      .tk_if (tif.slave)
   );

   always #5 clk = ~clk;

   // Model: time as seconds of day, mode 0=idle 1=run 2=pause.
   int m_t    = 0;
   int m_st   = 0;
   bit m_lerr = 1'b0;

   function automatic bit bcd_ok(input logic [23:0] v);
      int d[6];
      for (int i = 0; i < 6; i++) begin
         d[i] = int'(v[4*i +: 4]);
         if (d[i] > 9) return 1'b0;
      end
      return ((d[5]*10 + d[4]) < 24) && ((d[3]*10 + d[2]) < 60) && ((d[1]*10 + d[0]) < 60);
   endfunction

   function automatic int bcd2sec(input logic [23:0] v);
      int h, m, s;
      h = int'(v[23:20])*10 + int'(v[19:16]);
      m = int'(v[15:12])*10 + int'(v[11:8]);
      s = int'(v[7:4])*10 + int'(v[3:0]);
      return (h*60 + m)*60 + s;
   endfunction

   function automatic logic [23:0] sec2bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10)};
   endfunction

   function automatic void model_next(input int t_i, input int st_i, input bit tk, input bit sa,
                                      input bit sp, input bit cl, input bit ld,
                                      input logic [23:0] lt,
                                      output int t_o, output int st_o, output bit le_o);
      t_o  = t_i;
      st_o = st_i;
      le_o = 1'b0;
      if (cl) begin
         t_o  = 0;
         st_o = 0;
      end else if (ld) begin
         if (st_i != 1) begin
            if (bcd_ok(lt)) begin
               t_o  = bcd2sec(lt);
               st_o = 2;
            end else begin
               le_o = 1'b1;
            end
         end
      end else begin
         if (st_i == 1 && tk) t_o = (t_i + 1) % 86400;
         if (sp) begin
            if (st_i == 1) st_o = 2;
         end else if (sa) begin
            if (st_i != 1) st_o = 1;
         end
      end
   endfunction

   always @(posedge clk or posedge reset) begin
      int nt, ns;
      bit nl;
      if (reset) begin
         m_t    <= 0;
         m_st   <= 0;
         m_lerr <= 1'b0;
      end else begin
         model_next(m_t, m_st, tif.tick, tif.start, tif.stop, tif.clear, tif.load,
                    tif.load_time, nt, ns, nl);
         m_t    <= nt;
         m_st   <= ns;
         m_lerr <= nl;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("time", {8'h00, tif.hours, tif.minutes, tif.seconds}, {8'h00, sec2bcd(m_t)});
      chk("running", {31'd0, tif.running}, {31'd0, (m_st == 1)});
      chk("load_err", {31'd0, tif.load_err}, {31'd0, m_lerr});
      chk("day_tick", {31'd0, tif.day_tick},
          {31'd0, (m_st == 1) && tif.tick && (m_t == 86399) && !tif.clear && !tif.load});
   endtask

   always @(negedge clk) compare_outputs();

   task automatic drive(input bit tk, input bit sa, input bit sp, input bit cl, input bit ld,
                        input logic [23:0] lt);
      @(posedge clk);
      #2;
      tif.tick      = tk;
      tif.start     = sa;
      tif.stop      = sp;
      tif.clear     = cl;
      tif.load      = ld;
      tif.load_time = lt;
   endtask

   task automatic settle();
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
   endtask

   task automatic chk_time(input string name, input logic [23:0] exp);
      chk(name, {8'h00, tif.hours, tif.minutes, tif.seconds}, {8'h00, exp});
   endtask

   initial begin
      bit          last_tk;
      bit          tk, sa, sp, cl, ld;
      logic [23:0] lt;

      tif.tick = 0; tif.start = 0; tif.stop = 0; tif.clear = 0; tif.load = 0; tif.load_time = '0;
      #1 reset = 1'b1;
      @(negedge clk);
      chk_time("reset_time", 24'h000000);
      chk("reset_running", {31'd0, tif.running}, 32'd0);
      chk("reset_load_err", {31'd0, tif.load_err}, 32'd0);
      chk("reset_day_tick", {31'd0, tif.day_tick}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // 61 ticks, 4 cycles apart
      drive(0, 1, 0, 0, 0, 24'h0);
      for (int i = 0; i < 61; i++) begin
         drive(1, 0, 0, 0, 0, 24'h0);
         repeat (3) drive(0, 0, 0, 0, 0, 24'h0);
      end
      settle();
      chk_time("count_61", 24'h000101);
      chk("count_running", {31'd0, tif.running}, 32'd1);

      // day wrap
      drive(0, 0, 0, 1, 0, 24'h0);
      drive(0, 0, 0, 0, 1, 24'h235958);
      settle();
      chk_time("load_235958", 24'h235958);
      chk("load_paused", {31'd0, tif.running}, 32'd0);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 0, 24'h0);
      drive(1, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("day_tick_first", {31'd0, tif.day_tick}, 32'd0);
      drive(0, 0, 0, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 0, 24'h0);
      drive(1, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("day_tick_second", {31'd0, tif.day_tick}, 32'd1);
      settle();
      chk_time("wrap_time", 24'h000000);
      chk("wrap_running", {31'd0, tif.running}, 32'd1);

      // stop and tick together
      drive(0, 0, 0, 1, 0, 24'h0);
      drive(0, 0, 0, 0, 1, 24'h000009);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(1, 0, 1, 0, 0, 24'h0);
      settle();
      chk_time("stop_tick_time", 24'h000010);
      chk("stop_tick_running", {31'd0, tif.running}, 32'd0);
      drive(1, 0, 0, 0, 0, 24'h0);
      settle();
      chk_time("paused_tick", 24'h000010);

      // load rejection
      drive(0, 0, 0, 0, 1, 24'h240000);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("err_240000", {31'd0, tif.load_err}, 32'd1);
      chk_time("err_time_kept", 24'h000010);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, tif.load_err}, 32'd0);
      drive(0, 0, 0, 0, 1, 24'h126000);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("err_126000", {31'd0, tif.load_err}, 32'd1);
      drive(0, 0, 0, 0, 1, 24'h123A00);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("err_123A00", {31'd0, tif.load_err}, 32'd1);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 1, 24'h120000);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(negedge clk);
      chk("run_load_no_err", {31'd0, tif.load_err}, 32'd0);
      chk("run_load_running", {31'd0, tif.running}, 32'd1);
      chk_time("run_load_ignored", 24'h000010);

      // clear beats start
      drive(0, 0, 1, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 1, 24'h054321);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(0, 1, 0, 1, 0, 24'h0);
      settle();
      chk_time("clear_start_time", 24'h000000);
      chk("clear_start_running", {31'd0, tif.running}, 32'd0);

      // asynchronous reset mid-run
      drive(0, 0, 0, 0, 1, 24'h101010);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 0, 24'h0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_time("async_reset_time", 24'h000000);
      chk("async_reset_running", {31'd0, tif.running}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      drive(1, 0, 0, 0, 0, 24'h0);
      settle();
      chk_time("post_reset_no_count", 24'h000000);
      drive(0, 1, 0, 0, 0, 24'h0);
      drive(1, 0, 0, 0, 0, 24'h0);
      settle();
      chk_time("post_reset_count", 24'h000001);

      // random phase
      last_tk = 1'b0;
      repeat (4000) begin
         tk = !last_tk && ($urandom_range(0, 1) == 1);
         last_tk = tk;
         cl = ($urandom_range(0, 99) < 2);
         ld = ($urandom_range(0, 99) < 4);
         sp = ($urandom_range(0, 99) < 5);
         sa = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 3))
            0:       lt = 24'($urandom);
            1:       lt = sec2bcd(int'($urandom_range(86385, 86399)));
            default: lt = sec2bcd(int'($urandom_range(0, 86399)));
         endcase
         drive(tk, sa, sp, cl, ld, lt);
      end
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

- Counts the 1 Hz enable from the prescaler into a 24-hour BCD time of day (HH:MM:SS), under a start/stop/clear/load control FSM.
- Sits directly downstream of the 100 MHz → 1 Hz prescaler; its `tick` input is the prescaler's `CEO`.
- Its BCD outputs feed the seven-segment display multiplexer.

## Interface
- No parameters. The limits 23:59:59 are fixed.
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-high reset.
- `tick`  in  1: one-cycle enable from the prescaler `CEO`; at most one per 2 cycles.
- `start`  in  1: one-cycle pulse, already debounced; enter or resume counting.
- `stop`  in  1: one-cycle pulse; pause counting.
- `clear`  in  1: one-cycle pulse; zero the time and go idle.
- `load`  in  1: one-cycle pulse; take `load_time`.
- `load_time`  in  24: BCD value `{H1,H0,M1,M0,S1,S0}`, 4 bits per digit.
- `hours`  out  8: BCD `{H1,H0}`, range 00–23.
- `minutes`  out  8: BCD `{M1,M0}`, range 00–59.
- `seconds`  out  8: BCD `{S1,S0}`, range 00–59.
- `running`  out  1: high in state RUN.
- `day_tick`  out  1: one-cycle pulse on the wrap 23:59:59 → 00:00:00.
- `load_err`  out  1: one-cycle registered pulse when a load is rejected.

## Operation
- FSM states:
  - IDLE: time 00:00:00.
  - RUN: counting.
  - PAUSE: frozen, time held.
- Transitions, evaluated each clock edge. Priority is `clear` > `load` > `stop` > `start`; only the highest-priority asserted request acts.
  - `clear` from any state → IDLE. Time ← 00:00:00.
  - `load` in IDLE or PAUSE with valid BCD → PAUSE. Time ← `load_time`.
  - `load` in RUN is ignored: no state change, no error.
  - `stop` in RUN → PAUSE.
  - `start` in IDLE or PAUSE → RUN.
  - `start` in RUN and `stop` outside RUN are no-ops.
- Load validity: every digit ≤ 9, S1 ≤ 5, M1 ≤ 5, and H1:H0 ≤ 23.
  - An invalid load leaves state and time unchanged and pulses `load_err` for one cycle.
- Counting: on an edge where the state is RUN, `tick` = 1, and neither `clear` nor `load` is asserted, increment the BCD time:
  - S0 9→0 carries into S1.
  - S1:S0 59→00 carries into minutes, with the same digit rules.
  - M1:M0 59→00 carries into hours.
  - Hours increment BCD; 23→00.
- A `stop` in the same cycle as a `tick` in RUN: the tick is counted, then the state goes to PAUSE.
- A `start` in the same cycle as a `tick` in IDLE or PAUSE: the tick is not counted.
- `day_tick` is combinational: `state == RUN && tick && time == 23:59:59 && !clear && !load`.
- Time digits never hold a non-BCD or out-of-range value.

## Timing
- Reset values: IDLE, all time digits 0, `running` = 0, `day_tick` = 0, `load_err` = 0.
  - Reset is asynchronous: outputs go to these values immediately, with no clock edge needed.
- Reset mid-count behaves like `clear`; counting resumes only after a `start`.
- Latencies:
  - `tick` → updated `seconds`: visible after the same edge, 1-cycle latency.
  - `start`/`stop` → `running`: 1 cycle.
  - `load` → outputs: 1 cycle.
  - `load_err`: asserted in the cycle after the rejected `load`, for exactly one cycle.
- `day_tick` is high in the same cycle as the final `tick`; `hours/minutes/seconds` read 00:00:00 one cycle later.
- All outputs except `day_tick` are registered.

## Test plan
- Reset, then `start`, then 61 ticks spaced 4 cycles apart → 00:01:01 and `running` = 1.
- `load` 23:59:58 in IDLE → PAUSE, time 23:59:58. Then `start` and 2 ticks:
  - `day_tick` is high for exactly one cycle, aligned with the 2nd tick.
  - Time is 00:00:00 and `running` stays 1.
- RUN at 00:00:09 with `stop` and `tick` in the same cycle → time 00:00:10 and state PAUSE. A further tick leaves the time at 00:00:10.
- Load rejection:
  - `load` 24:00:00 in PAUSE → `load_err` one-cycle pulse, time unchanged.
  - `load` 12:60:00 → rejected.
  - `load` 12:3A:00 → rejected.
  - `load` during RUN → ignored, no `load_err`.
- `clear` and `start` together in RUN at 05:43:21 → IDLE, 00:00:00, `running` = 0.
- Assert `reset` asynchronously between clock edges while in RUN at 10:10:10 → outputs zero before the next edge. After reset release, ticks do not count until a `start` is given.
